// File: rtl/tlc1543_scan_ctrl.sv
// Channel scheduler for the TLC1543 serial-ADC driver: round-robins the enabled
// channels, re-tags the one-frame-late results and keeps them in a result bank.
module tlc1543_scan_ctrl #(
  parameter int CH_NUM      = 11,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic [CH_NUM-1:0] ch_mask,
  input  logic              err_clr,
  input  logic              tlc_eoc_ok,
  input  logic [9:0]        adc_data_in,
  output logic [3:0]        tlc_channel_sw,
  output logic              res_valid,
  output logic [3:0]        res_channel,
  output logic [9:0]        res_data,
  output logic              scan_done,
  output logic              busy,
  output logic              timeout_err,
  input  logic [3:0]        rd_ch,
  output logic [9:0]        rd_data
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  localparam logic [3:0]  CH_LAST  = 4'(CH_NUM - 1);
  localparam logic [16:0] CNT_LAST = 17'(TIMEOUT_CYC - 1);

  function automatic logic [3:0] lowest_ch(input logic [CH_NUM-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [3:0] highest_ch(input logic [CH_NUM-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < CH_NUM; i++) if (m[i]) r = 4'(i);
    return r;
  endfunction

  // Lowest enabled channel above c, wrapping to the lowest enabled one.
  function automatic logic [3:0] next_ch(input logic [3:0] c, input logic [CH_NUM-1:0] m);
    logic [3:0] r;
    r = lowest_ch(m);
    for (int i = CH_NUM - 1; i >= 0; i--) if (m[i] && (4'(i) > c)) r = 4'(i);
    return r;
  endfunction

  state_t      state, state_nx;
  logic        eoc_d;
  logic        fe;
  logic        mask_any;
  logic [3:0]  cur_ch, pend_ch;
  logic [16:0] tmo_cnt;
  logic        start, advance, take_pend, publish, tmo_hit;
  logic [9:0]  bank [CH_NUM];

  assign fe       = eoc_d & ~tlc_eoc_ok;
  assign mask_any = |ch_mask;
  assign busy     = (state != IDLE);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    advance   = 1'b0;
    take_pend = 1'b0;
    publish   = 1'b0;
    tmo_hit   = 1'b0;
    // A frame end arriving on the last counted cycle still counts as progress.
    if (state != IDLE && !fe && tmo_cnt == CNT_LAST) begin
      tmo_hit  = 1'b1;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (scan_en && mask_any) begin
          start    = 1'b1;
          state_nx = PRIME;
        end
        PRIME: if (fe) begin
          take_pend = 1'b1;
          advance   = 1'b1;
          state_nx  = RUN;
        end
        RUN: if (fe) begin
          publish   = 1'b1;
          take_pend = 1'b1;
          if (scan_en && mask_any) advance  = 1'b1;
          else                     state_nx = FLUSH;
        end
        FLUSH: if (fe) begin
          publish  = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      eoc_d          <= 1'b0;
      cur_ch         <= '0;
      pend_ch        <= '0;
      tlc_channel_sw <= '0;
      res_valid      <= 1'b0;
      res_channel    <= '0;
      res_data       <= '0;
      scan_done      <= 1'b0;
      timeout_err    <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      eoc_d     <= tlc_eoc_ok;
      res_valid <= publish;
      scan_done <= publish && mask_any && (pend_ch == highest_ch(ch_mask));
      if (publish) begin
        res_channel <= pend_ch;
        res_data    <= adc_data_in;
      end
      if (start) begin
        cur_ch         <= lowest_ch(ch_mask);
        tlc_channel_sw <= lowest_ch(ch_mask);
      end
      if (take_pend) pend_ch <= cur_ch;
      if (advance) begin
        cur_ch         <= next_ch(cur_ch, ch_mask);
        tlc_channel_sw <= next_ch(cur_ch, ch_mask);
      end
      if (state == IDLE || fe || tmo_hit) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 17'd1;
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  // NOTE: the bank is built from resettable flops rather than a RAM macro,
  // because every entry must read back as zero straight after reset.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) bank[i] <= '0;
      rd_data <= '0;
    end else begin
      if (publish && pend_ch <= CH_LAST) bank[pend_ch] <= adc_data_in;
      rd_data <= (rd_ch <= CH_LAST) ? bank[rd_ch] : '0;
    end
  end

endmodule

// File: tb/tb_tlc1543_scan_ctrl.sv
// Bench for tlc1543_scan_ctrl: frame-level driver model, table-driven scan,
// hand-written corner sequences and random episodes against a frame model.
module tb_tlc1543_scan_ctrl;

  localparam int TMO = 300;

  logic        clk_50m = 1'b0;
  logic        rst_n, scan_en, err_clr, tlc_eoc_ok;
  logic [10:0] ch_mask;
  logic [9:0]  adc_data_in;
  logic [3:0]  rd_ch;
  logic [3:0]  tlc_channel_sw, res_channel;
  logic        res_valid, scan_done, busy, timeout_err;
  logic [9:0]  res_data, rd_data;

  tlc1543_scan_ctrl #(.CH_NUM(11), .TIMEOUT_CYC(TMO)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
    .err_clr(err_clr), .tlc_eoc_ok(tlc_eoc_ok), .adc_data_in(adc_data_in),
    .tlc_channel_sw(tlc_channel_sw), .res_valid(res_valid), .res_channel(res_channel),
    .res_data(res_data), .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err),
    .rd_ch(rd_ch), .rd_data(rd_data)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct packed {
    logic       valid;
    logic [3:0] ch;
    logic [9:0] data;
    logic       done;
  } res_t;

  typedef struct {
    logic [9:0] data;
    logic [3:0] addr;
    logic       valid;
    logic [3:0] ch;
    logic       done;
  } vec_t;

  res_t       rq[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] mbank [16];
  logic [9:0] rd_fe;
  logic [3:0] a;
  logic [9:0] old;
  vec_t       tbl [8];

  always @(negedge clk_50m)
    if (res_valid || scan_done) rq.push_back(res_t'{res_valid, res_channel, res_data, scan_done});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Enabled channels as a sorted list; the scan order follows directly from it.
  function automatic logic [3:0] m_next(input int c, input logic [10:0] m);
    int en[$];
    int r;
    for (int i = 0; i < 11; i++) if (m[i]) en.push_back(i);
    r = en[0];
    for (int j = en.size() - 1; j >= 0; j--) if (en[j] > c) r = en[j];
    return 4'(r);
  endfunction

  function automatic logic [3:0] m_top(input logic [10:0] m);
    int r;
    r = 0;
    for (int i = 0; i < 11; i++) if (m[i]) r = i;
    return 4'(r);
  endfunction

  // One ADC frame: busy high for hi+1 cycles, result valid at the falling edge.
  task automatic run_frame(input logic [9:0] d, input int hi, output logic [3:0] addr);
    logic [3:0] a_end;
    @(negedge clk_50m);
    adc_data_in = 10'($urandom);
    tlc_eoc_ok  = 1'b1;
    addr        = tlc_channel_sw;
    repeat (hi) @(negedge clk_50m);
    adc_data_in = d;
    @(negedge clk_50m);
    a_end      = tlc_channel_sw;
    tlc_eoc_ok = 1'b0;
    check("sw_stable", a_end, addr);
    @(negedge clk_50m);
    rd_fe = rd_data;
    repeat (2) @(negedge clk_50m);
  endtask

  task automatic expect_res(input string name, input logic [3:0] ch, input logic [9:0] d,
                            input logic done);
    res_t r;
    if (rq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no result seen, expected ch %0d data 0x%0h", name, ch, d);
    end else begin
      r = rq.pop_front();
      check({name, "_valid"}, r.valid, 1'b1);
      check({name, "_ch"}, r.ch, ch);
      check({name, "_data"}, r.data, d);
      check({name, "_done"}, r.done, done);
    end
    mbank[ch] = d;
  endtask

  task automatic expect_none(input string name);
    check(name, rq.size(), 0);
    rq.delete();
  endtask

  task automatic check_bank();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_50m);
      rd_ch = 4'(i);
      @(negedge clk_50m);
      check($sformatf("bank_rd[%0d]", i), rd_data, (i > 10) ? 10'd0 : mbank[i]);
    end
  endtask

  task automatic check_idle_outputs(input string p);
    check({p, "_sw"}, tlc_channel_sw, 0);
    check({p, "_valid"}, res_valid, 0);
    check({p, "_ch"}, res_channel, 0);
    check({p, "_data"}, res_data, 0);
    check({p, "_done"}, scan_done, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_err"}, timeout_err, 0);
    check({p, "_rd"}, rd_data, 0);
  endtask

  task automatic episode(input int n);
    logic [3:0]  cur, prev, ad;
    logic [10:0] m;
    logic [9:0]  d;
    bit          have_prev;
    have_prev = 0;
    prev      = '0;
    m         = 11'($urandom_range(1, 2047));
    ch_mask   = m;
    scan_en   = 1'b1;
    cur       = m_next(-1, m);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        m       = 11'($urandom_range(1, 2047));
        ch_mask = m;
      end
      if (k == n - 1) scan_en = 1'b0;
      d = 10'($urandom);
      run_frame(d, $urandom_range(1, 6), ad);
      check("rnd_addr", ad, cur);
      if (have_prev) expect_res("rnd_res", prev, d, prev == m_top(m));
      else           expect_none("rnd_prime");
      prev      = cur;
      have_prev = 1;
      if (k < n - 1) cur = m_next(cur, m);
    end
    d = 10'($urandom);
    run_frame(d, $urandom_range(1, 6), ad);
    check("rnd_flush_addr", ad, prev);
    expect_res("rnd_flush", prev, d, prev == m_top(m));
    check("rnd_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; scan_en = 1'b0; err_clr = 1'b0; tlc_eoc_ok = 1'b0;
    ch_mask = '0; adc_data_in = '0; rd_ch = '0;
    for (int i = 0; i < 16; i++) mbank[i] = '0;
    tbl[0] = '{10'h101, 4'd0,  1'b0, 4'd0,  1'b0};
    tbl[1] = '{10'h102, 4'd7,  1'b1, 4'd0,  1'b0};
    tbl[2] = '{10'h103, 4'd10, 1'b1, 4'd7,  1'b0};
    tbl[3] = '{10'h104, 4'd0,  1'b1, 4'd10, 1'b1};
    tbl[4] = '{10'h105, 4'd7,  1'b1, 4'd0,  1'b0};
    tbl[5] = '{10'h106, 4'd10, 1'b1, 4'd7,  1'b0};
    tbl[6] = '{10'h107, 4'd0,  1'b1, 4'd10, 1'b1};
    tbl[7] = '{10'h108, 4'd7,  1'b1, 4'd0,  1'b0};

    repeat (3) @(negedge clk_50m);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk_50m);
    check_idle_outputs("post_rst");

    // Single channel: PRIME result discarded, every result ends a scan.
    ch_mask = 11'h001; scan_en = 1'b1;
    run_frame(10'h155, 4, a); check("t1_addr0", a, 0); expect_none("t1_prime");
    run_frame(10'h2AA, 4, a); check("t1_addr1", a, 0); expect_res("t1_first", 0, 10'h2AA, 1);
    run_frame(10'h0F0, 4, a); expect_res("t1_second", 0, 10'h0F0, 1);
    scan_en = 1'b0;
    run_frame(10'h333, 4, a); expect_res("t1_stop", 0, 10'h333, 1);
    run_frame(10'h0CC, 4, a); expect_res("t1_flush", 0, 10'h0CC, 1);
    check("t1_idle", busy, 0);

    // Channels 0, 7, 10 from the vector table.
    ch_mask = 11'h481; scan_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].data, 4, a);
      check($sformatf("tbl_addr[%0d]", i), a, tbl[i].addr);
      if (tbl[i].valid) expect_res($sformatf("tbl_res[%0d]", i), tbl[i].ch, tbl[i].data, tbl[i].done);
      else              expect_none("tbl_prime");
    end
    check_bank();

    // Stop while channel 7 is addressed: it is still flushed out.
    run_frame(10'h201, 4, a); check("t3_addr10", a, 10); expect_res("t3_r7", 7, 10'h201, 0);
    run_frame(10'h202, 4, a); check("t3_addr0", a, 0); expect_res("t3_r10", 10, 10'h202, 1);
    scan_en = 1'b0;
    run_frame(10'h203, 4, a); check("t3_addr7", a, 7); expect_res("t3_r0", 0, 10'h203, 0);
    rd_ch = 4'd7;
    old   = mbank[7];
    run_frame(10'h204, 4, a); check("t3_hold7", a, 7);
    check("t3_rd_old", rd_fe, old);
    expect_res("t3_flush7", 7, 10'h204, 0);
    check("t3_rd_new", rd_data, 10'h204);
    check("t3_idle", busy, 0);
    for (int i = 0; i < 20; i++) run_frame(10'($urandom), 3, a);
    expect_none("t3_quiet");

    // Mask shrinks to channel 10 while channel 1 is addressed.
    ch_mask = 11'h003; scan_en = 1'b1;
    run_frame(10'h011, 4, a); check("t4_a0", a, 0); expect_none("t4_prime");
    ch_mask = 11'h400;
    run_frame(10'h022, 4, a); check("t4_a1", a, 1); expect_res("t4_r0", 0, 10'h022, 0);
    run_frame(10'h033, 4, a); check("t4_a2", a, 10); expect_res("t4_r1", 1, 10'h033, 0);
    run_frame(10'h044, 4, a); check("t4_a3", a, 10); expect_res("t4_r10a", 10, 10'h044, 1);
    run_frame(10'h055, 4, a); check("t4_a4", a, 10); expect_res("t4_r10b", 10, 10'h055, 1);
    scan_en = 1'b0;
    run_frame(10'h066, 4, a); expect_res("t4_r10c", 10, 10'h066, 1);
    run_frame(10'h077, 4, a); expect_res("t4_flush", 10, 10'h077, 1);
    check("t4_idle", busy, 0);

    // Timeout from RUN, clear, then a second timeout racing err_clr.
    ch_mask = 11'h001; scan_en = 1'b1;
    run_frame(10'h3FF, 4, a); expect_none("t5_prime");
    run_frame(10'h001, 4, a); expect_res("t5_r0", 0, 10'h001, 1);
    scan_en = 1'b0;
    repeat (TMO - 10) @(negedge clk_50m);
    check("t5_pre_busy", busy, 1);
    check("t5_pre_err", timeout_err, 0);
    repeat (20) @(negedge clk_50m);
    check("t5_err", timeout_err, 1);
    check("t5_busy", busy, 0);
    expect_none("t5_no_res");
    err_clr = 1'b1;
    @(negedge clk_50m);
    err_clr = 1'b0;
    check("t5_cleared", timeout_err, 0);
    scan_en = 1'b1;
    @(negedge clk_50m);
    scan_en = 1'b0;
    repeat (TMO - 1) @(negedge clk_50m);
    check("t5_edge_busy", busy, 1);
    check("t5_edge_err", timeout_err, 0);
    err_clr = 1'b1;
    @(negedge clk_50m);
    err_clr = 1'b0;
    check("t5_set_wins", timeout_err, 1);
    check("t5_busy2", busy, 0);
    @(negedge clk_50m);
    err_clr = 1'b1;
    @(negedge clk_50m);
    err_clr = 1'b0;
    check("t5_cleared2", timeout_err, 0);

    // Random episodes against the frame model.
    for (int e = 0; e < 12; e++) episode($urandom_range(2, 9));
    check_bank();

    // Reset in the middle of a frame.
    ch_mask = 11'h481; scan_en = 1'b1;
    run_frame(10'h0AB, 4, a); expect_none("t6_prime");
    run_frame(10'h0CD, 4, a); expect_res("t6_r0", 0, 10'h0CD, 0);
    @(negedge clk_50m);
    tlc_eoc_ok = 1'b1;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b0; scan_en = 1'b0;
    @(negedge clk_50m);
    check_idle_outputs("t6_in_rst");
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    tlc_eoc_ok = 1'b0;
    repeat (3) @(negedge clk_50m);
    expect_none("t6_no_res");
    check_idle_outputs("t6_after");
    for (int i = 0; i < 16; i++) mbank[i] = '0;
    check_bank();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlc1543_scan_ctrl.md
Name: tlc1543_scan_ctrl

Overview:
- Channel scheduler for the TLC1543 serial-ADC driver.
- Drives the driver's 4-bit channel select and detects frame boundaries from the driver's EOC-qualified busy flag.
- Compensates for the ADC's one-frame result pipeline (the data shifted out in frame N belongs to the address written in frame N-1) and round-robins over a software-enabled channel mask.
- Publishes tagged results as a 1-cycle stream and into an 11-entry result bank readable by the host logic.

Parameters:
- CH_NUM, 11: analog inputs scanned (channels 0..10). Self-test codes 11..15 are never issued.
- TIMEOUT_CYC, 100000: clk_50m cycles without a frame end (2 ms) before a timeout is declared.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- scan_en  in  1  level; 1 = keep scanning.
- ch_mask  in  11  bit i = 1 enables channel i.
- err_clr  in  1  1-cycle pulse; clears timeout_err.
- tlc_eoc_ok  in  1  driver busy flag, high while a frame is shifting.
- adc_data_in  in  10  driver parallel result.
- tlc_channel_sw  out  4  channel address to the driver.
- res_valid  out  1  1-cycle strobe; a new result is available.
- res_channel  out  4  channel the result belongs to.
- res_data  out  10  conversion result.
- scan_done  out  1  1-cycle pulse with the result of the highest enabled channel.
- busy  out  1  1 when state is not IDLE.
- timeout_err  out  1  sticky error flag.
- rd_ch  in  4  result bank read address.
- rd_data  out  10  bank[rd_ch], registered.

Behaviour:
- Reset (async, rst_n = 0):
  - All outputs = 0; bank entries = 0; state = IDLE; cur_ch = pend_ch = 0; timeout counter = 0; eoc_d = 0.
  - Reset mid-frame abandons the frame with no result published.
- Frame end (fe):
  - eoc_d registers tlc_eoc_ok.
  - fe = eoc_d & ~tlc_eoc_ok, one cycle per falling edge.
  - adc_data_in is fully shifted and stable at fe.
  - tlc_channel_sw changes only in the cycle after fe, or on the IDLE->PRIME transition. It is held constant for the whole following frame.
- next(c): lowest enabled channel > c; if none, wraps to the lowest enabled channel. Evaluated on ch_mask as sampled in the fe cycle.
- States:
  - IDLE:
    - If scan_en = 1 and ch_mask != 0: cur_ch = lowest enabled channel, tlc_channel_sw = cur_ch, go to PRIME.
    - fe in IDLE is ignored.
  - PRIME (first frame carries a stale result, discarded):
    - On fe: pend_ch = cur_ch; cur_ch = next(cur_ch); tlc_channel_sw = next(cur_ch); go to RUN.
  - RUN, on fe:
    - res_data = adc_data_in; res_channel = pend_ch; res_valid = 1 for one cycle (the cycle after fe); bank[pend_ch] = adc_data_in.
    - scan_done pulses in the same cycle if pend_ch is the highest channel enabled in the sampled ch_mask.
    - Then pend_ch = cur_ch.
    - If scan_en = 1 and ch_mask != 0: cur_ch = next(cur_ch), address updated, stay in RUN.
    - Otherwise go to FLUSH; the address is held.
  - FLUSH:
    - On fe: publish the result for pend_ch as in RUN (scan_done rule applies), then go to IDLE.
    - scan_en re-asserting during FLUSH does not abort FLUSH; the controller restarts from IDLE.
- Channel clearing: a channel removed from ch_mask after being addressed still has its pending result published. A channel is published even if its mask bit is 0 at publish time.
- Timeout:
  - The counter increments every cycle while state != IDLE and is cleared on fe.
  - At TIMEOUT_CYC-1: timeout_err = 1, state = IDLE, counter = 0, no result published.
  - err_clr clears timeout_err. Set wins when set and clear occur in the same cycle.
- Bank read: rd_data = bank[rd_ch] one cycle after rd_ch is presented. rd_ch > 10 returns 0. A write and a read of the same entry in the same cycle return the old value.
- Widths:
  - Channel indices are 4 bits; comparisons are unsigned.
  - The timeout counter is 17 bits and saturates only through the timeout reset.

Test Plan:
- Reset, then ch_mask = 11'h001, scan_en = 1, with a frame model returning 10'h155 then 10'h2AA → PRIME frame discarded; first res_valid has res_channel = 0, res_data = 10'h2AA; scan_done pulses on every result.
- ch_mask = 11'h481 (channels 0, 7, 10), 8 frames → tlc_channel_sw sequence 0,7,10,0,7,10,… (one per frame); results tagged 0,7,10,… lag by one frame; scan_done only with channel 10; bank[0], bank[7], bank[10] match the model.
- scan_en dropped mid-RUN after channel 7 is addressed → one more res_valid for 7 in FLUSH, then busy = 0; no further res_valid for 20 frames.
- ch_mask changed from 11'h003 to 11'h400 while channel 1 is addressed → channel 1 still published; next addresses are 10,10,…; no wrap to 0.
- tlc_eoc_ok held low for 100000 cycles in RUN → timeout_err = 1, busy = 0, no res_valid; err_clr pulse → timeout_err = 0; err_clr coincident with a second timeout → timeout_err stays 1.
- rst_n asserted mid-frame, then released → all outputs 0, rd_data = 0 for rd_ch = 0..15; rd_ch = 12 always returns 0.
